// File: rtl/regfile_writeback_queue.sv
// Writeback queue feeding the register file's single write port, with a pending
// scoreboard and optional read forwarding (enabled by REGFILE_WBQ_FORWARD_EN).
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [4:0]               InReg,
    input  logic [WIDTH-1:0]         InData,
    input  logic                     Stall,
    output logic [4:0]               WriteRegister,
    output logic [WIDTH-1:0]         WriteData,
    output logic                     RegWrite,
    input  logic [4:0]               ReadRegister1,
    input  logic [4:0]               ReadRegister2,
    output logic                     Fwd1Hit,
    output logic                     Fwd2Hit,
    output logic [WIDTH-1:0]         Fwd1Data,
    output logic [WIDTH-1:0]         Fwd2Data,
    output logic [31:0]              Pending,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       reg_q [DEPTH];
    logic [4:0]       reg_d [DEPTH];
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic not_empty;
    logic push;
    logic pop;

    assign not_empty = (count_q != '0);
    assign InReady   = Reset_n && (count_q < CW'(DEPTH));
    assign RegWrite  = Reset_n && not_empty && !Stall;
    // r0 writes complete the handshake but never occupy an entry
    assign push      = InValid && InReady && (InReg != 5'd0);
    assign pop       = RegWrite;
    assign Count     = count_q;

    always_comb begin
        vld_d   = vld_q;
        reg_d   = reg_q;
        dat_d   = dat_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + AW'(1);
        end
        // push and pop never share a slot: push requires a free entry
        if (push) begin
            vld_d[tail_q] = 1'b1;
            reg_d[tail_q] = InReg;
            dat_d[tail_q] = InData;
            tail_d        = tail_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            reg_q   <= reg_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        WriteRegister = '0;
        WriteData     = '0;
        if (Reset_n && not_empty) begin
            WriteRegister = reg_q[head_q];
            WriteData     = dat_q[head_q];
        end
    end

    // Rebuilt from the valid entries each cycle, so duplicates clear correctly
    always_comb begin
        Pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) Pending[reg_q[i]] = 1'b1;
        end
        Pending[0] = 1'b0;
        if (!Reset_n) Pending = '0;
    end

`ifdef REGFILE_WBQ_FORWARD_EN
    logic [AW-1:0] idx;

    // Walk oldest to newest so the newest match wins
    always_comb begin
        Fwd1Hit  = 1'b0;
        Fwd2Hit  = 1'b0;
        Fwd1Data = '0;
        Fwd2Data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + AW'(k);
            if (Reset_n && vld_q[idx] && (reg_q[idx] == ReadRegister1) &&
                (ReadRegister1 != 5'd0)) begin
                Fwd1Hit  = 1'b1;
                Fwd1Data = dat_q[idx];
            end
            if (Reset_n && vld_q[idx] && (reg_q[idx] == ReadRegister2) &&
                (ReadRegister2 != 5'd0)) begin
                Fwd2Hit  = 1'b1;
                Fwd2Data = dat_q[idx];
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{ReadRegister1, ReadRegister2};
    assign Fwd1Hit   = 1'b0;
    assign Fwd2Hit   = 1'b0;
    assign Fwd1Data  = '0;
    assign Fwd2Data  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              InValid;
    logic              InReady;
    logic [4:0]        InReg;
    logic [WIDTH-1:0]  InData;
    logic              Stall;
    logic [4:0]        WriteRegister;
    logic [WIDTH-1:0]  WriteData;
    logic              RegWrite;
    logic [4:0]        ReadRegister1, ReadRegister2;
    logic              Fwd1Hit, Fwd2Hit;
    logic [WIDTH-1:0]  Fwd1Data, Fwd2Data;
    logic [31:0]       Pending;
    logic [2:0]        Count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]       r;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t mq[$];
    logic [WIDTH-1:0] rf [32];

    always #5 Clk = ~Clk;

    regfile_writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .InReg(InReg), .InData(InData), .Stall(Stall),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .Fwd1Hit(Fwd1Hit), .Fwd2Hit(Fwd2Hit), .Fwd1Data(Fwd1Data), .Fwd2Data(Fwd2Data),
        .Pending(Pending), .Count(Count)
    );

    // Advance one clock and apply the same edge to the reference model
    task automatic tick();
        bit rdy, wr, psh;
        rdy = Reset_n && (mq.size() < DEPTH);
        wr  = Reset_n && (mq.size() != 0) && !Stall;
        psh = InValid && rdy && (InReg != 5'd0);
        @(posedge Clk);
        #1;
        if (!Reset_n) mq.delete();
        else begin
            if (wr) begin
                rf[mq[0].r] = mq[0].d;
                void'(mq.pop_front());
            end
            if (psh) mq.push_back('{r: InReg, d: InData});
        end
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [WIDTH-1:0] d);
        InValid = 1'b1; InReg = r; InData = d;
        tick();
        InValid = 1'b0;
    endtask

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) if (mq[i].r != 5'd0) p[mq[i].r] = 1'b1;
        return Reset_n ? p : 32'd0;
    endfunction

    function automatic logic [WIDTH:0] m_fwd(input logic [4:0] rr);
        logic [WIDTH:0] res = '0;
`ifdef REGFILE_WBQ_FORWARD_EN
        foreach (mq[i]) if (Reset_n && rr != 5'd0 && mq[i].r == rr) res = {1'b1, mq[i].d};
`endif
        return res;
    endfunction

    task automatic test_reset();
        Reset_n = 1'b0; InValid = 1'b1; InReg = 5'd3; InData = 32'h55;
        Stall = 1'b0; ReadRegister1 = 5'd3; ReadRegister2 = 5'd0;
        tick(); tick();
        total++;
        if ({Count, RegWrite, InReady, Pending, Fwd1Hit, Fwd2Hit, WriteRegister, WriteData} !== '0) begin
            bad++;
            $display("FAIL reset: count=%0d rw=%b rdy=%b pend=%h f1=%b f2=%b wr=%0d wd=%h required all zero",
                     Count, RegWrite, InReady, Pending, Fwd1Hit, Fwd2Hit, WriteRegister, WriteData);
        end
        InValid = 1'b0;
        Reset_n = 1'b1;
        #1;
        total++;
        if (InReady !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", InReady); end
    endtask

    task automatic test_single();
        Stall = 1'b0;
        push(5'd5, 32'hDEADBEEF);
        total++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF ||
            Pending[5] !== 1'b1 || Count !== 3'd1) begin
            bad++;
            $display("FAIL single_head: rw=%b wr=%0d wd=%h p5=%b cnt=%0d want 1/5/deadbeef/1/1",
                     RegWrite, WriteRegister, WriteData, Pending[5], Count);
        end
        tick();
        total++;
        if (Count !== 3'd0 || Pending !== 32'd0 || RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL single_after: cnt=%0d pend=%h rw=%b want 0/0/0", Count, Pending, RegWrite);
        end
    endtask

    task automatic test_full_stall();
        Stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h11 * i);
        total++;
        if (Count !== 3'd4 || InReady !== 1'b0 || RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL full_stall: cnt=%0d rdy=%b rw=%b want 4/0/0", Count, InReady, RegWrite);
        end
        push(5'd9, 32'h99);
        total++;
        if (Count !== 3'd4 || Pending[9] !== 1'b0) begin
            bad++;
            $display("FAIL fifth_push: cnt=%0d p9=%b want 4/0", Count, Pending[9]);
        end
        Stall = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData !== 32'h11 * i) begin
                bad++;
                $display("FAIL drain_order[%0d]: rw=%b wr=%0d wd=%h want 1/%0d/%h",
                         i, RegWrite, WriteRegister, WriteData, i, 32'h11 * i);
            end
            tick();
        end
        total++;
        if (RegWrite !== 1'b0 || Count !== 3'd0) begin
            bad++;
            $display("FAIL drain_empty: rw=%b cnt=%0d want 0/0", RegWrite, Count);
        end
    endtask

    task automatic test_r0();
        InValid = 1'b1; InReg = 5'd0; InData = 32'h1234;
        #1;
        total++;
        if (InReady !== 1'b1) begin bad++; $display("FAIL r0_ready: got %b want 1", InReady); end
        tick();
        InValid = 1'b0;
        #1;
        total++;
        if (Count !== 3'd0 || RegWrite !== 1'b0 || Pending[0] !== 1'b0) begin
            bad++;
            $display("FAIL r0_discard: cnt=%0d rw=%b p0=%b want 0/0/0", Count, RegWrite, Pending[0]);
        end
    endtask

    task automatic test_dup_forward();
        logic exp_hit;
        logic [WIDTH-1:0] exp_data;
`ifdef REGFILE_WBQ_FORWARD_EN
        exp_hit = 1'b1; exp_data = 32'hB;
`else
        exp_hit = 1'b0; exp_data = 32'h0;
`endif
        Stall = 1'b1;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd0;
        #1;
        total++;
        if (Fwd1Hit !== exp_hit || Fwd1Data !== exp_data || Fwd2Hit !== 1'b0 || Fwd2Data !== '0) begin
            bad++;
            $display("FAIL fwd_newest: h1=%b d1=%h h2=%b d2=%h want %b/%h/0/0",
                     Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data, exp_hit, exp_data);
        end
        Stall = 1'b0;
        #1;
        total++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 32'hA) begin
            bad++;
            $display("FAIL dup_first: rw=%b wr=%0d wd=%h want 1/7/a", RegWrite, WriteRegister, WriteData);
        end
        tick();
        total++;
        if (Pending[7] !== 1'b1 || WriteData !== 32'hB || RegWrite !== 1'b1) begin
            bad++;
            $display("FAIL dup_second: p7=%b wd=%h rw=%b want 1/b/1", Pending[7], WriteData, RegWrite);
        end
        tick();
        total++;
        if (Pending[7] !== 1'b0 || Fwd1Hit !== 1'b0 || rf[7] !== 32'hB) begin
            bad++;
            $display("FAIL dup_clear: p7=%b h1=%b model_rf7=%h want 0/0/b", Pending[7], Fwd1Hit, rf[7]);
        end
    endtask

    task automatic test_full_pop();
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(10 + i), 32'h100 + i);
        Stall = 1'b0; InValid = 1'b1; InReg = 5'd20; InData = 32'h2020;
        #1;
        total++;
        if (InReady !== 1'b0 || RegWrite !== 1'b1) begin
            bad++;
            $display("FAIL full_pop_refuse: rdy=%b rw=%b want 0/1", InReady, RegWrite);
        end
        tick();
        InValid = 1'b0;
        #1;
        total++;
        if (Count !== 3'd3 || InReady !== 1'b1 || Pending[20] !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_after: cnt=%0d rdy=%b p20=%b want 3/1/0", Count, InReady, Pending[20]);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) push(5'(24 + i), 32'hC0 + i);
        Reset_n = 1'b0; Stall = 1'b0;
        #1;
        total++;
        if (RegWrite !== 1'b0 || Pending !== 32'd0 || InReady !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_low: rw=%b pend=%h rdy=%b want 0/0/0", RegWrite, Pending, InReady);
        end
        tick();
        Reset_n = 1'b1;
        #1;
        total++;
        if (Count !== 3'd0 || Pending !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_after: cnt=%0d pend=%h want 0/0", Count, Pending);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_mid_commit[%0d]: rw=%b want 0", i, RegWrite); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [WIDTH:0] f1, f2;
        logic [42:0]    exp_drain;
        for (int n = 0; n < 400; n++) begin
            Reset_n       = ($urandom_range(0, 39) != 0);
            InValid       = $urandom_range(0, 2) != 0;
            InReg         = 5'($urandom_range(0, 7));
            InData        = $urandom;
            Stall         = $urandom_range(0, 3) == 0;
            ReadRegister1 = 5'($urandom_range(0, 7));
            ReadRegister2 = 5'($urandom_range(0, 7));
            #1;
            exp_drain = {Reset_n && mq.size() < DEPTH,
                         Reset_n && mq.size() != 0 && !Stall,
                         (Reset_n && mq.size() != 0) ? mq[0].r : 5'd0,
                         (Reset_n && mq.size() != 0) ? mq[0].d : 32'd0,
                         3'(mq.size())};
            total++;
            if ({InReady, RegWrite, WriteRegister, WriteData, Count} !== exp_drain) begin
                bad++;
                $display("FAIL rand_drain[%0d]: got %h want %h", n,
                         {InReady, RegWrite, WriteRegister, WriteData, Count}, exp_drain);
            end
            total++;
            if (Pending !== m_pending()) begin
                bad++;
                $display("FAIL rand_pending[%0d]: got %h want %h", n, Pending, m_pending());
            end
            f1 = m_fwd(ReadRegister1);
            f2 = m_fwd(ReadRegister2);
            total++;
            if ({Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data} !== {f1, f2}) begin
                bad++;
                $display("FAIL rand_fwd[%0d]: got %h want %h", n,
                         {Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data}, {f1, f2});
            end
            tick();
        end
        InValid = 1'b0;
        Reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_single();
        test_full_stall();
        test_r0();
        test_dup_forward();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
